// File: rtl/adder_pkg.sv
// Shared constants and FSM encoding for the byte-serial 32-bit adder.
// Contents: default slice count, slice width, and the controller state type.
// Imported by multicycle_adder_32bit and RippleCarryAdder_8bit.
package adder_pkg;

    // Number of 8-bit slices processed per addition (operand width = 8*NUM_BYTES).
    localparam int NUM_BYTES = 4;

    // Width of the shared ripple-carry slice.
    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/RippleCarryAdder_8bit.sv
// Purpose: 8-bit ripple-carry adder slice, shared by the byte-serial adder.
// Latency: purely combinational.
// Ports: in1/in2 operand bytes, c_in carry-in, sum result byte, c_out carry-out.
module RippleCarryAdder_8bit
    import adder_pkg::*;
(
    input  logic [SLICE_W-1:0] in1,
    input  logic [SLICE_W-1:0] in2,
    input  logic               c_in,
    output logic [SLICE_W-1:0] sum,
    output logic               c_out
);

    // carry[i] is the carry into bit i; carry[SLICE_W] leaves the slice.
    logic [SLICE_W:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign sum[i]       = in1[i] ^ in2[i] ^ carry[i];
        assign carry[i + 1] = (in1[i] & in2[i]) | (carry[i] & (in1[i] ^ in2[i]));
    end

    assign c_out = carry[SLICE_W];

endmodule

// File: rtl/multicycle_adder_32bit.sv
// Purpose: 32-bit add using one 8-bit slice over NUM_BYTES cycles, LSB byte first.
// Latency: done pulses NUM_BYTES cycles after start is accepted; busy meanwhile.
// Ports: start/in1/in2/c_in request; busy/done status; sum/c_out/overflow held results.
module multicycle_adder_32bit
    import adder_pkg::*;
#(
    parameter int NUM_BYTES = adder_pkg::NUM_BYTES
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [SLICE_W*NUM_BYTES-1:0] in1,
    input  logic [SLICE_W*NUM_BYTES-1:0] in2,
    input  logic                         c_in,
    output logic                         busy,
    output logic                         done,
    output logic [SLICE_W*NUM_BYTES-1:0] sum,
    output logic                         c_out,
    output logic                         overflow
);

    localparam int W     = SLICE_W * NUM_BYTES;
    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     part_q;
    logic [W-1:0]     sum_q;
    logic             c_out_q;
    logic             ovf_q;

    logic [SLICE_W-1:0] a_byte;
    logic [SLICE_W-1:0] b_byte;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic [W-1:0]       part_d;
    logic               ovf_d;

    // Byte-select muxes feeding the shared slice, and the partial result with
    // the current byte merged in. On the last byte part_d is the full sum, so
    // it can be loaded into the result register in the same edge.
    always_comb begin
        a_byte = a_q[idx_q * SLICE_W +: SLICE_W];
        b_byte = b_q[idx_q * SLICE_W +: SLICE_W];
        part_d = part_q;
        part_d[idx_q * SLICE_W +: SLICE_W] = slice_sum;
        // Signed overflow: operands agree in sign but the result does not.
        ovf_d  = (a_q[W-1] == b_q[W-1]) && (part_d[W-1] != a_q[W-1]);
    end

    RippleCarryAdder_8bit u_slice (
        .in1   (a_byte),
        .in2   (b_byte),
        .c_in  (carry_q),
        .sum   (slice_sum),
        .c_out (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    // Accepting in DONE gives back-to-back adds with no idle gap.
                    if (start) begin
                        a_q     <= in1;
                        b_q     <= in2;
                        carry_q <= c_in;
                        idx_q   <= '0;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // start is deliberately ignored here: no re-sampling, no queueing.
                    part_q  <= part_d;
                    carry_q <= slice_cout;
                    if (idx_q == LAST_IDX) begin
                        sum_q   <= part_d;
                        c_out_q <= slice_cout;
                        ovf_q   <= ovf_d;
                        idx_q   <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Status is decoded from registered state only, so busy and done are exclusive.
    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_multicycle_adder_32bit.sv
module tb_multicycle_adder_32bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        c_in;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        c_out;
    logic        overflow;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          done_cyc;
    } exp_t;

    exp_t exp_q[$];

    multicycle_adder_32bit #(.NUM_BYTES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in1      (in1),
        .in2      (in2),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: plain wide arithmetic on the operands as integers.
    task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic c, input int accept_cyc);
        exp_t   e;
        logic [32:0] u;
        longint s;
        u = {1'b0, a} + {1'b0, b} + {32'd0, c};
        s = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
        e.sum      = u[31:0];
        e.cout     = u[32];
        e.ovf      = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.done_cyc = accept_cyc + 4;
        exp_q.push_back(e);
    endtask

    // Called just after a negedge. Start is sampled at the coming posedge;
    // returns at the negedge where the next start may be driven (gap 0 = back-to-back).
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic c, input int gap);
        in1   = a;
        in2   = b;
        c_in  = c;
        start = 1'b1;
        push_exp(a, b, c, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        in1   = $urandom;
        in2   = $urandom;
        c_in  = 1'($urandom_range(0, 1));
        repeat (4 + gap) @(negedge clk);
    endtask

    // Monitor: pops an expectation whenever the DUT presents done.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy && done) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL busy_done_overlap: got busy=1 done=1, expected exclusive");
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("sum", sum, e.sum);
                    chk("c_out", {31'd0, c_out}, {31'd0, e.cout});
                    chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        c_in  = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_c_out", {31'd0, c_out}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors.
        issue(32'h0000006D, 32'h0000004D, 1'b0, 1);
        issue(32'h0000006D, 32'h0000004D, 1'b1, 1);
        issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 0);
        issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 2);
        issue(32'h80000000, 32'h80000000, 1'b0, 1);
        issue(32'h7FFFFFFF, 32'h00000000, 1'b1, 0);

        // Second start mid-run is ignored; operands change while running.
        in1   = 32'h12345678;
        in2   = 32'h11111111;
        c_in  = 1'b0;
        start = 1'b1;
        push_exp(32'h12345678, 32'h11111111, 1'b0, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        in1   = 32'hDEADBEEF;
        in2   = 32'h01010101;
        c_in  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in1   = $urandom;
        in2   = $urandom;
        repeat (5) @(negedge clk);
        chk("ignored_start_no_extra", 32'(exp_q.size()), 32'd0);

        // Reset during the cycle ending at E2: discard, all outputs clear.
        in1   = 32'h0F0F0F0F;
        in2   = 32'h01010101;
        c_in  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
        chk("midrun_rst_done", {31'd0, done}, 32'd0);
        chk("midrun_rst_sum", sum, 32'd0);
        chk("midrun_rst_c_out", {31'd0, c_out}, 32'd0);
        chk("midrun_rst_overflow", {31'd0, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(32'h00000010, 32'h00000020, 1'b0, 1);

        // start held high: one result every 5 cycles.
        in1   = 32'h000000FF;
        in2   = 32'h00000001;
        c_in  = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_exp(32'h000000FF, 32'h00000001, 1'b0, cyc + 1 + 5 * k);
        end
        repeat (16) @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);

        // Randomized adds with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            issue($urandom, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(negedge clk);
        chk("pending_results", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
